// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO constants and Gray-code helper.
package fifo_pkg;

    localparam int ADDRSIZE_DEF = 4;
    localparam int DSIZE_DEF    = 8;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/rptr_empty_fwft_sync_set2.sv
// sync_set2: two-flop synchroniser with asynchronous active-high set.
module sync_set2 (
    input  logic clk,
    input  logic set,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/rptr_empty_fwft.sv
// rptr_empty_fwft: read pointer, synchronised empty flag and one-entry FWFT output register.
module rptr_empty_fwft
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int DSIZE    = DSIZE_DEF
) (
    input  logic                rclk,
    input  logic                rrstn_n,
    input  logic                aempty_n,
    input  logic [DSIZE-1:0]    rdata_mem,
    input  logic                dout_ready,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE-1:0] rptr,
    output logic                rempty,
    output logic [DSIZE-1:0]    dout,
    output logic                dout_valid
);

    logic [ADDRSIZE-1:0] rbin_q, rbin_d, rbnext;
    logic [ADDRSIZE-1:0] rptr_q, rptr_d;
    logic [DSIZE-1:0]    dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                rempty_set, fetch;

    // Empty asserts the instant the comparator or reset says so; release is synchronised.
    assign rempty_set = !rrstn_n || !aempty_n;

    sync_set2 u_empty_sync (
        .clk (rclk),
        .set (rempty_set),
        .d   (~aempty_n),
        .q   (rempty)
    );

    assign fetch  = !rempty && (!dout_valid_q || dout_ready);
    assign rbnext = rbin_q + 1'b1;

    always_comb begin
        rbin_d       = fetch ? rbnext : rbin_q;
        rptr_d       = fetch ? ADDRSIZE'(bin2gray(32'(rbnext))) : rptr_q;
        dout_d       = fetch ? rdata_mem : dout_q;
        dout_valid_d = fetch || (dout_valid_q && !dout_ready);
    end

    always_ff @(posedge rclk or negedge rrstn_n) begin
        if (!rrstn_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign raddr      = rbin_q;
    assign rptr       = rptr_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule
